ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; the send side paired with the existing PS/2 keyboard receiver.
//  Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared
//  open-drain ps2_clk/ps2_data lines. Drives the lines via active-high pull-low enables only.
//  Sits beside the keyboard receiver at top level; all logic is in the system clock domain.
// PARAMETERS
//  INHIBIT_CYCLES  5000     clk cycles ps2_clk is held low before the start bit (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  1000000  max clk cycles without a device falling edge before abort (20 ms @ 50 MHz)
// PORTS
//  clk          in   1  system clock; all logic on its rising edge
//  rst          in   1  synchronous, active-high reset
//  tx_data      in   8  command byte; sampled when tx_valid & tx_ready
//  tx_valid     in   1  request to send tx_data
//  tx_ready     out  1  high only in IDLE
//  ps2_clk      in   1  raw PS/2 clock line (asynchronous)
//  ps2_data     in   1  raw PS/2 data line (asynchronous)
//  ps2_clk_oe   out  1  1 = pull ps2_clk low; 0 = release
//  ps2_data_oe  out  1  1 = pull ps2_data low; 0 = release
//  busy         out  1  high in every state except IDLE
//  done         out  1  1-cycle pulse when a frame completes (ACK or NACK)
//  ack_err      out  1  1-cycle pulse, coincident with done, when the device did not ACK
//  timeout_err  out  1  1-cycle pulse on timeout abort; done stays low
// BEHAVIOUR
//  Reset: state IDLE; both oe=0; done/ack_err/timeout_err=0; tx_ready=1; busy=0.
//   Reset mid-frame releases both lines on the next clk edge and discards the byte.
//  Input sync: 2-flop synchronisers on ps2_clk/ps2_data plus a prev-clk register.
//   fall = prev & ~sync_clk. Edge seen 3 clk cycles after the pin transition.
//  Accept: on tx_valid & tx_ready, latch tx_data and parity = ~^tx_data (odd); go to INHIBIT.
//   tx_valid outside IDLE is ignored; no queuing.
//  INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles.
//   On the last cycle set data_oe=1 (start bit = 0); next cycle clk_oe=0; go to START.
//  START: clk released, data_oe=1; wait for fall #1 and go to DATA with bit index 0.
//  DATA: on each fall, present the next bit: data_oe = ~bit. Fall #1 presents D0 and fall #8
//   presents D7, LSB first. Fall #9 presents parity (go to STOP).
//  STOP: on fall #10, data_oe=0 (stop bit = 1); go to ACK.
//  ACK: on fall #11, sample sync_data; 0 = ACK, 1 = NACK. Go to WAIT_IDLE.
//  WAIT_IDLE: wait until sync_clk=1 & sync_data=1, then pulse done (plus ack_err if NACK);
//   go to IDLE. tx_ready rises on the cycle after done.
//  Timeout: the counter clears on entering START and on every fall. It runs in START through
//   WAIT_IDLE. On reaching TIMEOUT_CYCLES: oe=0 on both lines, pulse timeout_err, go to IDLE.
//  A fall during INHIBIT (device glitch) is ignored. The frame is exactly 11 falls.
//  data_oe changes only in the cycle after a detected fall; it never changes while the
//   synchronised clk is high.
// TESTING (bench: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200, device model clocks at 40-clk period)
//  1 rst held, tx_valid=1 -> oe=0/0, tx_ready=1, busy=0, no pulses; release rst -> accept next cycle.
//  2 send 0xED -> clk_oe high exactly 8 cycles; the device sees start 0, then bits 1,0,1,1,0,1,1,1,
//   parity 1, stop 1; device ACKs -> done=1 for one cycle, ack_err=0.
//  3 send 0xFF, then 0x01 back-to-back -> parity 1 and parity 0; second byte accepted only
//   after the first done.
//  4 device leaves data high at fall #11 -> done and ack_err pulse together; lines released.
//  5 device never clocks after START -> timeout_err pulses 200 cycles after START entry;
//   oe=0/0; done never pulses; next byte accepted.
//  6 rst asserted at DATA bit 4 -> next cycle oe=0/0, IDLE; tx_valid pulse with busy=1 is ignored.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard over the open-drain pair.
// Latency: INHIBIT_CYCLES of clock inhibit, then 11 device clock falls; device edges seen 3 clk later.
// Backpressure: tx_ready only in IDLE; tx_valid at any other time is dropped, nothing is queued.
//
// Ports:
//   clk, rst                   system clock, synchronous active-high reset
//   tx_data/tx_valid/tx_ready  command byte handshake (accepted on tx_valid & tx_ready)
//   ps2_clk, ps2_data          raw (asynchronous) PS/2 lines
//   ps2_clk_oe, ps2_data_oe    1 = pull the line low, 0 = release
//   busy                       high in every state except IDLE
//   done / ack_err             frame-complete pulse; ack_err marks a NACK
//   timeout_err                abort pulse when the device stops clocking
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // Start bit goes out on the last inhibit cycle, clock is released one cycle later.
    localparam logic [INH_W-1:0] INH_START_BIT = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [INH_W-1:0] INH_LAST      = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST       = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_DATA,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           state;
    logic             clk_meta;
    logic             clk_sync;
    logic             clk_prev;
    logic             data_meta;
    logic             data_sync;
    logic             fall;
    logic             active;
    logic             to_hit;
    logic [7:0]       shreg;
    logic             parity;
    logic [2:0]       bit_cnt;
    logic             nack;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;

    // Synchronisers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    assign fall   = clk_prev & ~clk_sync;
    // Timeout watch covers everything from START through WAIT_IDLE.
    assign active = (state == S_START) || (state == S_DATA) || (state == S_STOP) ||
                    (state == S_ACK)   || (state == S_WAIT_IDLE);
    assign to_hit = active && !fall && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            shreg       <= '0;
            parity      <= 1'b0;
            bit_cnt     <= '0;
            nack        <= 1'b0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
        end else begin
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;

            if (active) begin
                to_cnt <= fall ? '0 : to_cnt + 1'b1;
            end

            if (to_hit) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                timeout_err <= 1'b1;
                busy        <= 1'b0;
                state       <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tx_valid && tx_ready) begin
                            shreg       <= tx_data;
                            parity      <= ~^tx_data;
                            inh_cnt     <= '0;
                            ps2_clk_oe  <= 1'b1;
                            ps2_data_oe <= 1'b0;
                            tx_ready    <= 1'b0;
                            busy        <= 1'b1;
                            state       <= S_INHIBIT;
                        end else begin
                            // Held low during the done/abort cycle, so ready rises one cycle later.
                            tx_ready <= 1'b1;
                        end
                    end

                    // Device clock glitches while we hold the clock low are ignored here.
                    S_INHIBIT: begin
                        inh_cnt <= inh_cnt + 1'b1;
                        if (inh_cnt == INH_START_BIT) begin
                            ps2_data_oe <= 1'b1;
                        end
                        if (inh_cnt == INH_LAST) begin
                            ps2_clk_oe <= 1'b0;
                            to_cnt     <= '0;
                            state      <= S_START;
                        end
                    end

                    S_START: begin
                        if (fall) begin
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= shreg >> 1;
                            bit_cnt     <= '0;
                            state       <= S_DATA;
                        end
                    end

                    // Falls 2..8 shift out D1..D7; fall 9 (bit_cnt == 7) sends parity.
                    S_DATA: begin
                        if (fall) begin
                            if (bit_cnt == 3'd7) begin
                                ps2_data_oe <= ~parity;
                                state       <= S_STOP;
                            end else begin
                                ps2_data_oe <= ~shreg[0];
                                shreg       <= shreg >> 1;
                                bit_cnt     <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    S_STOP: begin
                        if (fall) begin
                            ps2_data_oe <= 1'b0;
                            state       <= S_ACK;
                        end
                    end

                    S_ACK: begin
                        if (fall) begin
                            nack  <= data_sync;
                            state <= S_WAIT_IDLE;
                        end
                    end

                    S_WAIT_IDLE: begin
                        if (clk_sync && data_sync) begin
                            done    <= 1'b1;
                            ack_err <= nack;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end

                    default: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
